// File: rtl/ram_pkg.sv
// Widths shared between the FIFO controller and the ram it fronts.
package ram_pkg;

   localparam int unsigned RAM_ADDR_WIDTH = 4;
   localparam int unsigned RAM_DATA_WIDTH = 8;
   localparam int unsigned RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

   typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
   typedef logic [RAM_DATA_WIDTH-1:0] data_t;
   typedef logic [RAM_ADDR_WIDTH:0]   ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer with an extra wrap bit above the ram address bits.
module fifo_ptr #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Push/pop FIFO controller driving an external single-port-pair ram.
// Holds only pointers and status; the data lives in the ram.
module ram_fifo_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = RAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = RAM_DATA_WIDTH,
   parameter int unsigned AFULL_THRESH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_vld,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  wr_enb,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_enb,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                push_accept;
   logic                pop_accept;

   fifo_ptr #(.W(ADDR_WIDTH+1)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push_accept),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.W(ADDR_WIDTH+1)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop_accept),
      .ptr (rd_ptr)
   );

   // Status is derived from the registered pointers, so it lags the accepting edge by one cycle.
   always_comb begin
      empty       = (wr_ptr == rd_ptr);
      full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
      count       = wr_ptr - rd_ptr;
      almost_full = (count >= AFULL_LVL);
   end

   // Gating with rst keeps the ram strobes quiet while reset is held, whatever the requesters do.
   always_comb begin
      push_accept = rst && push && !full;
      pop_accept  = rst && pop && !empty;
      wr_enb      = push_accept;
      wr_addr     = wr_ptr[ADDR_WIDTH-1:0];
      wr_data     = push_accept ? push_data : '0;
      rd_enb      = pop_accept;
      rd_addr     = rd_ptr[ADDR_WIDTH-1:0];
      pop_data    = ram_rd_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pop_vld   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_vld <= pop_accept;
         if (push && full) begin
            overflow <= 1'b1;
         end
         if (pop && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller sitting directly upstream of the single-port-pair ram block.
- Converts a push/pop stream interface into the ram's wr_enb/wr_addr/wr_data and rd_enb/rd_addr strobes, and returns ram rd_data as pop data.
- Tracks occupancy, full/empty/almost-full and sticky overflow/underflow errors; holds no storage of its own beyond pointers and flags.

Parameters:
- ADDR_WIDTH, 4, ram address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width; must equal the ram's data width.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); release is synchronised externally.
- push  in  1  upstream write request.
- push_data  in  DATA_WIDTH  word to enqueue.
- pop  in  1  downstream read request.
- pop_data  out  DATA_WIDTH  dequeued word; direct from ram_rd_data.
- pop_vld  out  1  pop_data valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push while full.
- underflow  out  1  sticky: pop while empty.
- wr_enb  out  1  to ram.
- wr_addr  out  ADDR_WIDTH  to ram.
- wr_data  out  DATA_WIDTH  to ram.
- rd_enb  out  1  to ram.
- rd_addr  out  ADDR_WIDTH  to ram.
- ram_rd_data  in  DATA_WIDTH  from ram rd_data; valid one clk after rd_enb.

Behaviour:
- Reset (rst=0, immediate): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=underflow=0, pop_vld=0.
- Reset also drives wr_enb=rd_enb=0, wr_addr=rd_addr=0 and wr_data=0.
- Pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the ram; the MSB is the wrap bit.
- full = (wr_ptr MSB != rd_ptr MSB) && low bits equal; empty = pointers equal; count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Push accept = push && !full.
  - Accept drives wr_enb=1, wr_addr=wr_ptr[ADDR_WIDTH-1:0] and wr_data=push_data combinationally in the same cycle.
  - wr_ptr increments at that edge.
- Pop accept = pop && !empty.
  - Accept drives rd_enb=1 and rd_addr=rd_ptr[ADDR_WIDTH-1:0] combinationally; rd_ptr increments at that edge.
  - pop_vld is registered: 1 in the cycle after an accepted pop, else 0.
  - pop_data = ram_rd_data, continuously; latency from accepted pop to data is 1 cycle.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: push accepted, pop rejected, underflow set; no same-cycle bypass.
  - Full: pop accepted, push rejected, overflow set. This guarantees wr_addr != rd_addr in any cycle where both strobes are high.
- Rejected requests produce no ram strobe and no pointer change.
- overflow/underflow remain set until reset.
- Flags and count are combinational from the registered pointers, so they update the cycle after the accepting edge.
- Pointer wrap: after DEPTH accepted pushes from reset, the wrap bit toggles and wr_addr returns to 0.
- Reset mid-operation: all state clears immediately; any in-flight pop_vld is dropped; ram contents are not cleared.

Decomposition:
- Shared package ram_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults, shared with ram;
  - DEPTH derived constant;
  - typedefs addr_t, data_t, ptr_t (ADDR_WIDTH+1).
- One natural sub-module, fifo_ptr: a wrap-bit pointer counter with increment enable and async active-low clear, instantiated twice for wr_ptr and rd_ptr.
- Status and flag logic stays in the top module.

Test Plan:
- Reset/idle: hold rst=0 for 2 clk, release -> empty=1, full=0, count=0, wr_enb=rd_enb=0, overflow=underflow=0.
- Fill and drain: push 0xA0..0xAF (16 words); count reaches 16, full=1, almost_full=1 from count 12. Then pop 16 times -> pop_vld each following cycle, pop_data 0xA0..0xAF in order, empty=1 at end.
- Overflow/underflow: push 0x55 while full -> wr_enb=0, count stays 16, overflow=1 and stays set. Pop while empty -> rd_enb=0, underflow=1.
- Simultaneous push and pop at count=5 -> wr_enb=rd_enb=1, wr_addr != rd_addr, count stays 5.
  - Simultaneous at empty -> only the push is accepted, count=1, underflow=1.
  - Simultaneous at full -> only the pop is accepted, count=15, overflow=1.
- Wrap-around: 20 push/pop pairs of 0x00..0x13 with occupancy held at 3 -> wr_addr wraps 15->0, data returns in order, count never exceeds 4.
- Mid-operation reset: assert rst=0 for 1 clk with count=7 and a pop in flight -> count=0, empty=1 and pop_vld=0 immediately. A subsequent push of 0x3C then a pop returns 0x3C.
